// File: rtl/trigger_pulse_generator.sv
// trigger_pulse_generator
// Turns the single-cycle trigger strobe from the edge detector into a pulse
// with a programmable delay, width and idle polarity. Configuration and a
// fire counter are reached through the byte-wide serial register interface.
// Command codes: 0x30 CFG, 0x31 DELAY, 0x32 WIDTH, 0x33 STATUS.
module trigger_pulse_generator #(
  parameter int DELAY_W = 24,
  parameter int WIDTH_W = 16
) (
  input  logic        sampleclk,
  input  logic        reset,
  input  logic        trigger_in,
  input  logic [7:0]  reg_cmd,
  input  logic [15:0] reg_bytecount,
  input  logic [7:0]  reg_data_in,
  output logic [7:0]  reg_data_out,
  input  logic        reg_read,
  input  logic        reg_write,
  output logic        pulse_out,
  output logic        busy
);

  localparam int DELAY_BYTES = (DELAY_W + 7) / 8;
  localparam int WIDTH_BYTES = (WIDTH_W + 7) / 8;

  localparam logic [7:0] CMD_CFG    = 8'h30;
  localparam logic [7:0] CMD_DELAY  = 8'h31;
  localparam logic [7:0] CMD_WIDTH  = 8'h32;
  localparam logic [7:0] CMD_STATUS = 8'h33;

  localparam logic [DELAY_W-1:0]         DELAY_ONE   = {{(DELAY_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH_W-1:0]         WIDTH_ONE   = {{(WIDTH_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH_BYTES*8-1:0]   WIDTH_RESET = {{(WIDTH_BYTES*8-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_PULSE = 2'd2
  } state_t;

  // Host-visible registers. r_cfg = {ONESHOT, POL, ARM}.
  logic [2:0]               r_cfg;
  logic [DELAY_BYTES*8-1:0] r_delay;
  logic [WIDTH_BYTES*8-1:0] r_width;
  logic [7:0]               r_fire_count;

  // Burst state; counts are snapshots taken when a trigger is accepted.
  state_t             r_state;
  state_t             w_next_state;
  logic [DELAY_W-1:0] r_delay_cnt;
  logic [WIDTH_W-1:0] r_width_cnt;
  logic               r_pulse_out;
  logic               r_busy;

  logic               w_cfg_wr;
  logic               w_delay_wr;
  logic               w_width_wr;
  logic               w_status_wr;
  logic               w_accept;
  logic               w_enter_pulse;
  logic               w_pol_next;
  logic [DELAY_W-1:0] w_delay_val;
  logic [WIDTH_W-1:0] w_width_val;
  logic [7:0]         w_rd_data;

  assign w_cfg_wr    = reg_write & (reg_cmd == CMD_CFG) & (reg_bytecount == 16'd0);
  assign w_delay_wr  = reg_write & (reg_cmd == CMD_DELAY);
  assign w_width_wr  = reg_write & (reg_cmd == CMD_WIDTH);
  assign w_status_wr = reg_write & (reg_cmd == CMD_STATUS) & (reg_bytecount < 16'd2);

  assign w_delay_val   = r_delay[DELAY_W-1:0];
  assign w_width_val   = r_width[WIDTH_W-1:0];
  assign w_accept      = (r_state == S_IDLE) & r_cfg[0] & trigger_in;
  assign w_enter_pulse = (w_next_state == S_PULSE) & (r_state != S_PULSE);
  // A CFG write lands together with the output level, so a new POL shows
  // on pulse_out in the same cycle it becomes readable.
  assign w_pol_next    = w_cfg_wr ? reg_data_in[1] : r_cfg[1];

  // FSM state register
  always_ff @(posedge sampleclk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: a zero delay goes straight to PULSE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_delay_val == '0) begin
            w_next_state = S_PULSE;
          end else begin
            w_next_state = S_DELAY;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_DELAY: begin
        if (r_delay_cnt == DELAY_ONE) begin
          w_next_state = S_PULSE;
        end else begin
          w_next_state = S_DELAY;
        end
      end
      S_PULSE: begin
        if (r_width_cnt == WIDTH_ONE) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_PULSE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Delay/width down-counters: latched on acceptance, a zero width becomes one
  always_ff @(posedge sampleclk or posedge reset) begin
    if (reset) begin
      r_delay_cnt <= '0;
      r_width_cnt <= WIDTH_ONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_delay_cnt <= w_delay_val;
            r_width_cnt <= (w_width_val == '0) ? WIDTH_ONE : w_width_val;
          end
        end
        S_DELAY: r_delay_cnt <= r_delay_cnt - DELAY_ONE;
        S_PULSE: r_width_cnt <= r_width_cnt - WIDTH_ONE;
        default: begin
          r_delay_cnt <= '0;
          r_width_cnt <= WIDTH_ONE;
        end
      endcase
    end
  end

  // CFG register: a host write overrides the one-shot ARM clear
  always_ff @(posedge sampleclk or posedge reset) begin
    if (reset) begin
      r_cfg <= 3'b000;
    end else if (w_cfg_wr) begin
      r_cfg <= reg_data_in[2:0];
    end else if (w_enter_pulse && r_cfg[2]) begin
      r_cfg[0] <= 1'b0;
    end
  end

  // DELAY and WIDTH byte registers; out-of-range byte indexes match nothing
  always_ff @(posedge sampleclk or posedge reset) begin
    if (reset) begin
      r_delay <= '0;
      r_width <= WIDTH_RESET;
    end else begin
      for (int b = 0; b < DELAY_BYTES; b++) begin
        if (w_delay_wr && (reg_bytecount == 16'(b))) begin
          r_delay[b*8 +: 8] <= reg_data_in;
        end
      end
      for (int b = 0; b < WIDTH_BYTES; b++) begin
        if (w_width_wr && (reg_bytecount == 16'(b))) begin
          r_width[b*8 +: 8] <= reg_data_in;
        end
      end
    end
  end

  // Fire counter: a STATUS write clears it even in the cycle of a fire
  always_ff @(posedge sampleclk or posedge reset) begin
    if (reset) begin
      r_fire_count <= 8'h00;
    end else if (w_status_wr) begin
      r_fire_count <= 8'h00;
    end else if (w_enter_pulse) begin
      r_fire_count <= r_fire_count + 8'h01;
    end
  end

  // Registered outputs, aligned with the state they describe
  always_ff @(posedge sampleclk or posedge reset) begin
    if (reset) begin
      r_pulse_out <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_pulse_out <= (w_next_state == S_PULSE) ? ~w_pol_next : w_pol_next;
      r_busy      <= (w_next_state != S_IDLE);
    end
  end

  // Read mux: zero when not reading, for unknown commands or past the register
  always_comb begin
    w_rd_data = 8'h00;
    if (reg_read) begin
      case (reg_cmd)
        CMD_CFG: begin
          if (reg_bytecount == 16'd0) begin
            w_rd_data = {5'b00000, r_cfg};
          end else begin
            w_rd_data = 8'h00;
          end
        end
        CMD_DELAY: begin
          if (reg_bytecount < 16'(DELAY_BYTES)) begin
            w_rd_data = 8'(r_delay >> {reg_bytecount, 3'b000});
          end else begin
            w_rd_data = 8'h00;
          end
        end
        CMD_WIDTH: begin
          if (reg_bytecount < 16'(WIDTH_BYTES)) begin
            w_rd_data = 8'(r_width >> {reg_bytecount, 3'b000});
          end else begin
            w_rd_data = 8'h00;
          end
        end
        CMD_STATUS: begin
          if (reg_bytecount == 16'd0) begin
            w_rd_data = {6'b000000, r_cfg[0], r_busy};
          end else if (reg_bytecount == 16'd1) begin
            w_rd_data = r_fire_count;
          end else begin
            w_rd_data = 8'h00;
          end
        end
        default: w_rd_data = 8'h00;
      endcase
    end else begin
      w_rd_data = 8'h00;
    end
  end

  assign reg_data_out = w_rd_data;
  assign pulse_out    = r_pulse_out;
  assign busy         = r_busy;

endmodule

// File: tb/tb_trigger_pulse_generator.sv
// tb_trigger_pulse_generator
// Directed scenarios followed by a randomized phase, all checked against a
// timeline model: each accepted trigger becomes a burst with known fire and
// end edges, from which busy, pulse_out, STATUS and fire_count follow.
module tb_trigger_pulse_generator;

  localparam logic [7:0] CMD_CFG    = 8'h30;
  localparam logic [7:0] CMD_DELAY  = 8'h31;
  localparam logic [7:0] CMD_WIDTH  = 8'h32;
  localparam logic [7:0] CMD_STATUS = 8'h33;

  logic        sampleclk = 1'b0;
  logic        reset = 1'b1;
  logic        trigger_in = 1'b0;
  logic [7:0]  reg_cmd = 8'h00;
  logic [15:0] reg_bytecount = 16'h0000;
  logic [7:0]  reg_data_in = 8'h00;
  logic [7:0]  reg_data_out;
  logic        reg_read = 1'b0;
  logic        reg_write = 1'b0;
  logic        pulse_out;
  logic        busy;

  always #5 sampleclk = ~sampleclk;

  trigger_pulse_generator dut (
    .sampleclk     (sampleclk),
    .reset         (reset),
    .trigger_in    (trigger_in),
    .reg_cmd       (reg_cmd),
    .reg_bytecount (reg_bytecount),
    .reg_data_in   (reg_data_in),
    .reg_data_out  (reg_data_out),
    .reg_read      (reg_read),
    .reg_write     (reg_write),
    .pulse_out     (pulse_out),
    .busy          (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: register contents plus the current burst as edge numbers
  logic [2:0] m_cfg;
  int         m_delay;
  int         m_width;
  logic [7:0] m_fire;
  bit         b_valid;
  int         b_start, b_fire, b_end;
  int         m_idle_from;
  int         m_edge;
  bit         m_busy, m_pulse;

  // Independent tallies over a measurement window
  int g_pulse, g_low, g_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cfg = 3'b000; m_delay = 0; m_width = 1; m_fire = 8'h00;
    b_valid = 1'b0; b_start = 0; b_fire = 0; b_end = 0;
    m_idle_from = 0; m_busy = 1'b0; m_pulse = 1'b0;
  endtask

  // One active edge: acceptance uses pre-edge registers, host writes win last
  task automatic model_edge();
    int e, w, bc;
    bit arm_old, osh_old;
    m_edge++;
    e = m_edge;
    arm_old = m_cfg[0];
    osh_old = m_cfg[2];
    if (trigger_in && arm_old && (e >= m_idle_from)) begin
      w = (m_width == 0) ? 1 : m_width;
      b_valid = 1'b1;
      b_start = e;
      b_fire  = e + m_delay;
      b_end   = e + m_delay + w - 1;
      m_idle_from = b_end + 2;
    end
    if (b_valid && (e == b_fire)) begin
      m_fire = m_fire + 8'd1;
      if (osh_old) m_cfg[0] = 1'b0;
    end
    if (reg_write) begin
      bc = int'(reg_bytecount);
      case (reg_cmd)
        CMD_CFG:    if (bc == 0) m_cfg = reg_data_in[2:0];
        CMD_DELAY:  if (bc < 3) m_delay = (m_delay & ~(32'hFF << (8*bc))) | (int'(reg_data_in) << (8*bc));
        CMD_WIDTH:  if (bc < 2) m_width = (m_width & ~(32'hFF << (8*bc))) | (int'(reg_data_in) << (8*bc));
        CMD_STATUS: if (bc < 2) m_fire = 8'h00;
        default: ;
      endcase
    end
    m_busy  = b_valid && (e >= b_start) && (e <= b_end);
    m_pulse = b_valid && (e >= b_fire) && (e <= b_end);
  endtask

  function automatic logic [7:0] model_read();
    int bc;
    bc = int'(reg_bytecount);
    if (!reg_read) return 8'h00;
    case (reg_cmd)
      CMD_CFG:    return (bc == 0) ? {5'b00000, m_cfg} : 8'h00;
      CMD_DELAY:  return (bc < 3) ? 8'((m_delay >> (8*bc)) & 255) : 8'h00;
      CMD_WIDTH:  return (bc < 2) ? 8'((m_width >> (8*bc)) & 255) : 8'h00;
      CMD_STATUS: begin
        if (bc == 0) return {6'b000000, m_cfg[0], m_busy};
        else if (bc == 1) return m_fire;
        else return 8'h00;
      end
      default: return 8'h00;
    endcase
  endfunction

  // Advance one clock, update the model, compare every output 1 time unit later
  task automatic step();
    logic exp_pulse;
    @(posedge sampleclk);
    if (!reset) model_edge();
    #1;
    exp_pulse = m_pulse ? ~m_cfg[1] : m_cfg[1];
    check("pulse_out", pulse_out, exp_pulse);
    check("busy", busy, m_busy);
    check("reg_data_out", reg_data_out, model_read());
    if (pulse_out === 1'b1) g_pulse++;
    if (pulse_out === 1'b0) g_low++;
    if (busy === 1'b1) g_busy++;
  endtask

  task automatic set_idle();
    trigger_in = 1'b0; reg_read = 1'b0; reg_write = 1'b0;
    reg_cmd = 8'h00; reg_bytecount = 16'h0000; reg_data_in = 8'h00;
  endtask

  task automatic wr(input logic [7:0] cmd, input logic [15:0] bc, input logic [7:0] d);
    reg_write = 1'b1; reg_cmd = cmd; reg_bytecount = bc; reg_data_in = d;
    step();
    set_idle();
  endtask

  task automatic rd_const(input string tag, input logic [7:0] cmd, input logic [15:0] bc, input logic [7:0] exp);
    reg_read = 1'b1; reg_cmd = cmd; reg_bytecount = bc;
    step();
    check(tag, reg_data_out, exp);
    set_idle();
  endtask

  task automatic trig();
    trigger_in = 1'b1;
    step();
    trigger_in = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int r, bc;
    model_reset();
    m_edge = 0;
    set_idle();
    reset = 1'b1;
    #1;
    check("rst_pulse_out", pulse_out, 1'b0);
    check("rst_busy", busy, 1'b0);
    step(); step();
    reset = 1'b0;
    rd_const("rst_cfg", CMD_CFG, 16'd0, 8'h00);
    rd_const("rst_delay0", CMD_DELAY, 16'd0, 8'h00);
    rd_const("rst_width0", CMD_WIDTH, 16'd0, 8'h01);
    rd_const("rst_status1", CMD_STATUS, 16'd1, 8'h00);

    // Delay 5, width 3: busy 8 cycles, pulse 3 cycles
    wr(CMD_DELAY, 16'd0, 8'd5);
    wr(CMD_WIDTH, 16'd0, 8'd3);
    wr(CMD_WIDTH, 16'd1, 8'd0);
    wr(CMD_CFG, 16'd0, 8'h01);
    g_busy = 0; g_pulse = 0;
    trig();
    repeat (11) step();
    check("t1_busy_cycles", g_busy, 8);
    check("t1_pulse_cycles", g_pulse, 3);
    rd_const("t1_fire", CMD_STATUS, 16'd1, 8'd1);

    // Delay 0, width 0: one-cycle pulse
    wr(CMD_DELAY, 16'd0, 8'd0);
    wr(CMD_WIDTH, 16'd0, 8'd0);
    g_pulse = 0;
    trig();
    check("t2_pulse_now", pulse_out, 1'b1);
    repeat (3) step();
    check("t2_pulse_cycles", g_pulse, 1);
    rd_const("t2_fire", CMD_STATUS, 16'd1, 8'd2);

    // One-shot: retrigger during burst and 100 cycles later both ignored
    wr(CMD_CFG, 16'd0, 8'h05);
    wr(CMD_DELAY, 16'd0, 8'd3);
    wr(CMD_WIDTH, 16'd0, 8'd2);
    g_pulse = 0;
    trig();
    step();
    trig();
    repeat (100) step();
    trig();
    repeat (10) step();
    check("t3_pulse_cycles", g_pulse, 2);
    rd_const("t3_status0", CMD_STATUS, 16'd0, 8'h00);
    rd_const("t3_fire", CMD_STATUS, 16'd1, 8'd3);

    // STATUS write in the same cycle as a fire: clear wins
    wr(CMD_CFG, 16'd0, 8'h01);
    wr(CMD_DELAY, 16'd0, 8'd0);
    trigger_in = 1'b1; reg_write = 1'b1; reg_cmd = CMD_STATUS; reg_bytecount = 16'd0; reg_data_in = 8'h00;
    step();
    set_idle();
    repeat (3) step();
    rd_const("clr_vs_fire", CMD_STATUS, 16'd1, 8'd0);

    // CFG write in the same cycle as the one-shot ARM clear: host wins
    wr(CMD_CFG, 16'd0, 8'h05);
    trigger_in = 1'b1; reg_write = 1'b1; reg_cmd = CMD_CFG; reg_bytecount = 16'd0; reg_data_in = 8'h05;
    step();
    set_idle();
    rd_const("cfg_vs_oneshot", CMD_CFG, 16'd0, 8'h05);
    repeat (3) step();
    rd_const("cfg_vs_oneshot_fire", CMD_STATUS, 16'd1, 8'd1);

    // POL=1, delay 2, width 4: idles high, low for 4 cycles
    wr(CMD_CFG, 16'd0, 8'h03);
    check("pol_idle_high", pulse_out, 1'b1);
    wr(CMD_DELAY, 16'd0, 8'd2);
    wr(CMD_WIDTH, 16'd0, 8'd4);
    g_low = 0;
    trig();
    repeat (10) step();
    check("pol_low_cycles", g_low, 4);
    check("pol_back_high", pulse_out, 1'b1);

    // Asynchronous reset in the middle of a pulse
    wr(CMD_CFG, 16'd0, 8'h01);
    wr(CMD_DELAY, 16'd0, 8'd1);
    wr(CMD_WIDTH, 16'd0, 8'd5);
    trig();
    step(); step();
    check("mid_pulse_high", pulse_out, 1'b1);
    check("mid_busy_high", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_pulse", pulse_out, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    model_reset();
    step(); step();
    reset = 1'b0;
    rd_const("post_rst_cfg", CMD_CFG, 16'd0, 8'h00);
    rd_const("post_rst_width", CMD_WIDTH, 16'd0, 8'h01);
    rd_const("post_rst_fire", CMD_STATUS, 16'd1, 8'h00);

    // Byte access and out-of-range handling
    wr(CMD_DELAY, 16'd0, 8'h01);
    wr(CMD_DELAY, 16'd1, 8'h02);
    wr(CMD_DELAY, 16'd2, 8'h03);
    rd_const("delay_b0", CMD_DELAY, 16'd0, 8'h01);
    rd_const("delay_b1", CMD_DELAY, 16'd1, 8'h02);
    rd_const("delay_b2", CMD_DELAY, 16'd2, 8'h03);
    wr(CMD_DELAY, 16'd3, 8'h55);
    rd_const("delay_b3", CMD_DELAY, 16'd3, 8'h00);
    rd_const("delay_b0_kept", CMD_DELAY, 16'd0, 8'h01);
    rd_const("width_b2", CMD_WIDTH, 16'd2, 8'h00);
    rd_const("unknown_cmd", 8'h77, 16'd0, 8'h00);
    reg_cmd = CMD_DELAY; reg_bytecount = 16'd0;
    step();
    check("read_low", reg_data_out, 8'h00);
    set_idle();

    // Fire count to 7, then a STATUS write clears it
    wr(CMD_DELAY, 16'd0, 8'h00);
    wr(CMD_DELAY, 16'd1, 8'h00);
    wr(CMD_DELAY, 16'd2, 8'h00);
    wr(CMD_WIDTH, 16'd0, 8'd1);
    wr(CMD_CFG, 16'd0, 8'h01);
    for (int i = 0; i < 7; i++) begin
      trig();
      step();
    end
    rd_const("fire7", CMD_STATUS, 16'd1, 8'd7);
    wr(CMD_STATUS, 16'd0, 8'hA5);
    rd_const("fire_cleared", CMD_STATUS, 16'd1, 8'd0);

    // Width change during DELAY only affects the next burst
    wr(CMD_DELAY, 16'd0, 8'd5);
    wr(CMD_WIDTH, 16'd0, 8'd3);
    g_pulse = 0;
    trig();
    step(); step();
    wr(CMD_WIDTH, 16'd0, 8'd10);
    repeat (12) step();
    check("latched_width", g_pulse, 3);
    g_pulse = 0;
    trig();
    repeat (20) step();
    check("new_width", g_pulse, 10);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      set_idle();
      trigger_in = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 11);
      case (r)
        0: begin
          d = 8'($urandom_range(0, 255));
          if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
          reg_write = 1'b1; reg_cmd = CMD_CFG;
          reg_bytecount = 16'($urandom_range(0, 1)); reg_data_in = d;
        end
        1: begin
          bc = $urandom_range(0, 3);
          reg_write = 1'b1; reg_cmd = CMD_DELAY; reg_bytecount = 16'(bc);
          reg_data_in = (bc == 0) ? 8'($urandom_range(0, 6)) : ((bc == 3) ? 8'($urandom_range(0, 255)) : 8'h00);
        end
        2: begin
          bc = $urandom_range(0, 2);
          reg_write = 1'b1; reg_cmd = CMD_WIDTH; reg_bytecount = 16'(bc);
          reg_data_in = (bc == 0) ? 8'($urandom_range(0, 5)) : ((bc == 2) ? 8'($urandom_range(0, 255)) : 8'h00);
        end
        3: begin
          reg_write = 1'b1; reg_cmd = CMD_STATUS;
          reg_bytecount = 16'($urandom_range(0, 2)); reg_data_in = 8'($urandom_range(0, 255));
        end
        4, 5, 6, 7: begin
          reg_read = ($urandom_range(0, 5) != 0);
          case ($urandom_range(0, 4))
            0: reg_cmd = CMD_CFG;
            1: reg_cmd = CMD_DELAY;
            2: reg_cmd = CMD_WIDTH;
            3: reg_cmd = CMD_STATUS;
            default: reg_cmd = 8'h77;
          endcase
          reg_bytecount = 16'($urandom_range(0, 4));
        end
        default: ;
      endcase
      step();
    end
    set_idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trigger_pulse_generator.md
# trigger_pulse_generator

Downstream stage of the edge detector. Takes the single-cycle `triggered` strobe and produces a programmable trigger output pulse on `pulse_out` after a configurable delay and with a configurable width. Delay, width, arming and polarity are set over the existing serial register interface. A fire counter is readable over the same interface. The generator ignores further triggers while a delay or pulse is in progress.

## Interface
- `DELAY_W`, default 24: width of the delay register, in cycles. Host-visible as 3 bytes.
- `WIDTH_W`, default 16: width of the pulse-width register, in cycles. Host-visible as 2 bytes.
- `sampleclk`  in  1  single clock for all logic, including register access.
- `reset`  in  1  asynchronous, active-high reset.
- `trigger_in`  in  1  trigger strobe from the edge detector, synchronous to `sampleclk`.
- `reg_cmd`  in  8  command select.
- `reg_bytecount`  in  16  byte index within the addressed register, little-endian.
- `reg_data_in`  in  8  write data.
- `reg_data_out`  out  8  read data, combinational.
- `reg_read`  in  1  read flag.
- `reg_write`  in  1  write flag.
- `pulse_out`  out  1  trigger output, registered.
- `busy`  out  1  high when the FSM is in DELAY or PULSE.

## Operation
- Registers, with reset values:
  - `TRIGGER_PULSE_CFG` (1 byte) = 0x00. Bit0 ARM. Bit1 POL (idle level of `pulse_out`; the active level is ~POL). Bit2 ONESHOT. Bits 7:3 read as 0.
  - `TRIGGER_PULSE_DELAY` (3 bytes) = 0.
  - `TRIGGER_PULSE_WIDTH` (2 bytes) = 1.
  - `TRIGGER_PULSE_STATUS` (2 bytes, read): byte0 = {6'b0, ARM, busy}, byte1 = fire_count. Any write to STATUS clears fire_count.
- Byte access:
  - Writes on `reg_write` load byte `reg_bytecount`.
  - `reg_bytecount` beyond the register size: write ignored, read returns 0.
  - `reg_data_out` is 0 when `reg_read` is low or for unknown commands.
- FSM states: IDLE, DELAY, PULSE.
- IDLE:
  - If ARM=1 and `trigger_in`=1, latch delay into a down-counter and width into a pulse counter. A width of 0 is latched as 1.
  - If delay=0, go to PULSE. Otherwise go to DELAY.
  - `trigger_in` with ARM=0 is ignored.
- DELAY: decrement the counter. When it reaches 1, go to PULSE.
- PULSE:
  - `pulse_out` is at the active level.
  - Decrement the pulse counter. When it reaches 1, return to IDLE.
  - On entering PULSE: fire_count += 1, wrapping at 8 bits. If ONESHOT=1, clear ARM.
- `trigger_in` during DELAY or PULSE is ignored. No queueing.
- Config writes during DELAY or PULSE do not affect the burst in progress, because values are latched at acceptance.
- Same-cycle conflicts:
  - A host CFG write in the same cycle as the ONESHOT auto-clear: the host write wins.
  - A host STATUS write in the same cycle as a fire: the clear wins and fire_count = 0.
- Clearing ARM mid-burst does not abort the burst.
- Reset, asserted asynchronously:
  - FSM goes to IDLE, all registers return to their reset values, `busy`=0.
  - `pulse_out`=0, which is the idle level for POL=0.
  - Mid-pulse reset ends the pulse immediately.

## Timing
- `trigger_in` is sampled high at edge N and accepted.
- `pulse_out` goes active from edge N+1+D.
- `pulse_out` stays active for exactly W cycles, where W = max(width, 1). It returns to idle at edge N+1+D+W.
- `busy` is high from edge N+1 through edge N+D+W. It is low at edge N+1+D+W.
- The earliest next accepted trigger is the one sampled at edge N+1+D+W.
- A register write at edge M is visible to reads and to trigger acceptance from edge M+1.
- Counters have no wrap-around: delay up to 2^24−1 and width up to 2^16−1 are exact.

## Test plan
- Delay=5, width=3, ARM=1, one `trigger_in` pulse at edge 10 -> `pulse_out` high on edges 16–18 and low at edge 19; `busy` high on edges 11–18; fire_count=1.
- Delay=0, width=0 -> single-cycle pulse at edge N+1; fire_count increments.
- ONESHOT=1, two triggers 100 cycles apart -> only the first fires; STATUS byte0 = 0x00 afterwards. A second trigger at edge N+2 during the burst is also ignored.
- POL=1, delay=2, width=4 -> `pulse_out` idles at 1 after a CFG write and goes low for 4 cycles. Reset asserted mid-pulse -> `pulse_out`=0 and `busy`=0 asynchronously.
- Byte access: write DELAY bytes 0/1/2 = 0x01/0x02/0x03 and read back 0x030201. Write to byte 3 -> ignored, reads 0. Write STATUS while fire_count=7 -> reads 0.
- Change width from 3 to 10 during DELAY -> the current pulse is 3 cycles and the next pulse is 10 cycles.
